// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and branch
// stalls, and the multi-cycle multiply/divide stall, with its own M/W shadow state.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       BranchD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic       MdStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushE,
    output logic       MdBusy
);

    localparam logic [3:0] MD_LAST = 4'(MD_LATENCY - 1);

    logic       regwrite_m_q, regwrite_m_d;
    logic       memtoreg_m_q, memtoreg_m_d;
    logic [4:0] writereg_m_q, writereg_m_d;
    logic       regwrite_w_q, regwrite_w_d;
    logic [4:0] writereg_w_q, writereg_w_d;
    logic [3:0] mdcnt_q, mdcnt_d;

    logic mdstall;
    logic lwstall;
    logic branchstall;
    logic e_hits_d;
    logic m_hits_d;

    // mdcnt counts cycles already spent in Execute; the final cycle does not stall.
    always_comb begin
        mdstall = 1'b0;
        mdcnt_d = 4'd0;
        if (MdStartE && (mdcnt_q < MD_LAST)) begin
            mdstall = 1'b1;
            mdcnt_d = mdcnt_q + 4'd1;
        end
    end

    always_comb begin
        regwrite_w_d = regwrite_m_q;
        writereg_w_d = writereg_m_q;
        regwrite_m_d = RegWriteE;
        memtoreg_m_d = MemtoRegE;
        writereg_m_d = WriteRegE;
        if (mdstall) begin
            regwrite_m_d = 1'b0;
            memtoreg_m_d = 1'b0;
            writereg_m_d = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            writereg_m_q <= 5'd0;
            regwrite_w_q <= 1'b0;
            writereg_w_q <= 5'd0;
            mdcnt_q      <= 4'd0;
        end else begin
            regwrite_m_q <= regwrite_m_d;
            memtoreg_m_q <= memtoreg_m_d;
            writereg_m_q <= writereg_m_d;
            regwrite_w_q <= regwrite_w_d;
            writereg_w_q <= writereg_w_d;
            mdcnt_q      <= mdcnt_d;
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        if ((RsE != 5'd0) && regwrite_m_q && (RsE == writereg_m_q))
            ForwardAE = 2'b10;
        else if ((RsE != 5'd0) && regwrite_w_q && (RsE == writereg_w_q))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if ((RtE != 5'd0) && regwrite_m_q && (RtE == writereg_m_q))
            ForwardBE = 2'b10;
        else if ((RtE != 5'd0) && regwrite_w_q && (RtE == writereg_w_q))
            ForwardBE = 2'b01;
    end

    assign ForwardAD = (RsD != 5'd0) && regwrite_m_q && (RsD == writereg_m_q);
    assign ForwardBD = (RtD != 5'd0) && regwrite_m_q && (RtD == writereg_m_q);

    // A branch resolves in Decode, so it must wait on an ALU result still in
    // Execute and on a load result still in Memory.
    assign e_hits_d = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign m_hits_d = (writereg_m_q != 5'd0) &&
                      ((writereg_m_q == RsD) || (writereg_m_q == RtD));

    assign lwstall     = MemtoRegE && RegWriteE && e_hits_d;
    assign branchstall = BranchD && ((RegWriteE && e_hits_d) || (memtoreg_m_q && m_hits_d));

    assign StallF = lwstall | branchstall | mdstall;
    assign StallD = lwstall | branchstall | mdstall;
    assign StallE = mdstall;
    assign FlushE = (lwstall | branchstall) & ~mdstall;
    assign MdBusy = (mdcnt_q != 4'd0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized
// traffic compared against a pipeline-history reference model.
module tb_hazard_ctrl;

  localparam int L = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE;
  logic       BranchD, RegWriteE, MemtoRegE, MdStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, MdBusy;

  hazard_ctrl #(.MD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushE(FlushE), .MdBusy(MdBusy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: history of instructions that left Execute (index 0 = M, 1 = W)
  typedef struct packed {
    logic       rw;
    logic       mt;
    logic [4:0] wr;
  } stage_t;

  stage_t         pipe[$];
  int             run_len;
  logic [10:0]    exp_q[$];
  int             n_checks;
  int             n_errors;

  task automatic model_reset();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    run_len = 0;
  endtask

  function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
    if (src != 0 && pipe[0].rw && src == pipe[0].wr) return 2'b10;
    if (src != 0 && pipe[1].rw && src == pipe[1].wr) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_mdstall();
    return MdStartE && ((run_len % L) != L - 1);
  endfunction

  function automatic logic [10:0] exp_outputs();
    logic lw, br, md, hit_e, hit_m, fad, fbd, busy;
    hit_e = (WriteRegE != 0) && (WriteRegE == RsD || WriteRegE == RtD);
    hit_m = (pipe[0].wr != 0) && (pipe[0].wr == RsD || pipe[0].wr == RtD);
    lw    = MemtoRegE && RegWriteE && hit_e;
    br    = BranchD && ((RegWriteE && hit_e) || (pipe[0].mt && hit_m));
    md    = exp_mdstall();
    fad   = (RsD != 0) && pipe[0].rw && (RsD == pipe[0].wr);
    fbd   = (RtD != 0) && pipe[0].rw && (RtD == pipe[0].wr);
    busy  = (run_len % L) != 0;
    return {exp_fwd_e(RsE), exp_fwd_e(RtE), fad, fbd,
            lw | br | md, lw | br | md, md, (lw | br) & ~md, busy};
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // scoreboard: model prediction queued, then matched field by field
  task automatic check_model(input string tag);
    logic [10:0] e;
    exp_q.push_back(exp_outputs());
    e = exp_q.pop_front();
    check_val({tag, ".fae"}, 8'(ForwardAE), 8'(e[10:9]));
    check_val({tag, ".fbe"}, 8'(ForwardBE), 8'(e[8:7]));
    check_val({tag, ".fad"}, 8'(ForwardAD), 8'(e[6]));
    check_val({tag, ".fbd"}, 8'(ForwardBD), 8'(e[5]));
    check_val({tag, ".stf"}, 8'(StallF),    8'(e[4]));
    check_val({tag, ".std"}, 8'(StallD),    8'(e[3]));
    check_val({tag, ".ste"}, 8'(StallE),    8'(e[2]));
    check_val({tag, ".fle"}, 8'(FlushE),    8'(e[1]));
    check_val({tag, ".mdb"}, 8'(MdBusy),    8'(e[0]));
  endtask

  // driver: called just after a falling edge, leaves inputs settled for 1 time unit
  task automatic apply(input logic [4:0] rsd, input logic [4:0] rtd, input logic br,
                       input logic [4:0] rse, input logic [4:0] rte, input logic [4:0] wre,
                       input logic rwe, input logic mte, input logic mds);
    RsD = rsd; RtD = rtd; BranchD = br;
    RsE = rse; RtE = rte; WriteRegE = wre;
    RegWriteE = rwe; MemtoRegE = mte; MdStartE = mds;
    #1;
  endtask

  task automatic tick();
    stage_t e;
    int     nxt;
    e   = exp_mdstall() ? stage_t'('0) : stage_t'({RegWriteE, MemtoRegE, WriteRegE});
    nxt = MdStartE ? run_len + 1 : 0;
    @(posedge clk);
    run_len = nxt;
    pipe.push_front(e);
    void'(pipe.pop_back());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_model("idle");
      tick();
    end
  endtask

  initial begin
    logic mds;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check_val("rst.all", {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD},
              8'h00);
    check_val("rst.rest", {5'd0, StallE, FlushE, MdBusy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // forward from M then W then none
    apply(0, 0, 0, 0, 0, 8, 1, 0, 0); check_model("s1.n0"); tick();
    apply(0, 0, 0, 8, 0, 0, 0, 0, 0); check_model("s1.n1");
    check_val("s1.fae_m", 8'(ForwardAE), 8'h2); tick();
    apply(0, 0, 0, 8, 0, 0, 0, 0, 0); check_model("s1.n2");
    check_val("s1.fae_w", 8'(ForwardAE), 8'h1); tick();
    apply(0, 0, 0, 8, 0, 0, 0, 0, 0); check_model("s1.n3");
    check_val("s1.fae_0", 8'(ForwardAE), 8'h0); tick();

    // M priority over W
    apply(0, 0, 0, 0, 0, 8, 1, 0, 0); check_model("s2.a"); tick();
    apply(0, 0, 0, 0, 0, 8, 1, 0, 0); check_model("s2.b"); tick();
    apply(0, 0, 0, 8, 8, 0, 0, 0, 0); check_model("s2.c");
    check_val("s2.prio", {4'd0, ForwardAE, ForwardBE}, 8'h0A); tick();
    idle(2);

    // load-use stall, then the consumer reaches Execute with the load in W
    apply(0, 9, 0, 0, 0, 9, 1, 1, 0); check_model("s3.ld");
    check_val("s3.stall", {4'd0, StallF, StallD, FlushE, StallE}, 8'h0E); tick();
    apply(0, 9, 0, 0, 0, 0, 0, 0, 0); check_model("s3.bub");
    check_val("s3.free", 8'(StallF), 8'h0); tick();
    apply(0, 0, 0, 9, 0, 0, 0, 0, 0); check_model("s3.use");
    check_val("s3.fae_w", 8'(ForwardAE), 8'h1); tick();
    idle(2);

    // branch waits one cycle, then forwards from M
    apply(10, 0, 1, 0, 0, 10, 1, 0, 0); check_model("s4.a");
    check_val("s4.stall", {5'd0, StallF, StallD, FlushE}, 8'h07); tick();
    apply(10, 0, 1, 0, 0, 0, 0, 0, 0); check_model("s4.b");
    check_val("s4.fwd", {5'd0, ForwardAD, StallF, FlushE}, 8'h04); tick();
    idle(2);

    // 4-cycle multiply: stalls cycles 1-3, busy cycles 2-4, M takes bubbles
    for (int c = 1; c <= L; c++) begin
      apply(0, 0, 0, 5, 0, 5, 1, 0, 1); check_model("s5.md");
      check_val("s5.ste", 8'(StallE), (c < L) ? 8'h1 : 8'h0);
      check_val("s5.busy", 8'(MdBusy), (c > 1) ? 8'h1 : 8'h0);
      if (c > 1) check_val("s5.bubble", 8'(ForwardAE), 8'h0);
      tick();
    end
    apply(0, 0, 0, 5, 0, 0, 0, 0, 0); check_model("s5.done");
    check_val("s5.fae_m", {5'd0, ForwardAE, MdBusy}, 8'h4); tick();
    idle(2);

    // register 0 never forwards or stalls; then reset aborts a multiply
    apply(0, 0, 1, 0, 0, 0, 1, 1, 0); check_model("s6.r0");
    check_val("s6.r0", {ForwardAE, ForwardBE, StallF, FlushE, ForwardAD, StallE}, 8'h00);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0); check_model("s6.r0w");
    check_val("s6.r0w", {4'd0, ForwardAE, ForwardBE}, 8'h00); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1); check_model("s6.m1"); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1); check_model("s6.m2");
    check_val("s6.busy", 8'(MdBusy), 8'h1);
    #1 rst_n = 1'b0;
    #1;
    check_val("s6.abort", 8'(MdBusy), 8'h0);
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0); check_model("s6.rst");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic over a small register set to provoke collisions
    mds = 1'b0;
    for (int i = 0; i < 400; i++) begin
      mds = mds ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mds);
      check_model("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4: number of cycles a multiply/divide op occupies Execute; legal range 1..15.
REQ-002 SHALL have ports, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- RsD, RtD  in  5 each  Decode source registers
- BranchD  in  1  Decode holds a branch that compares registers in Decode
- RsE, RtE  in  5 each  Execute source registers
- WriteRegE  in  5  Execute destination register
- RegWriteE  in  1  Execute instruction writes the register file
- MemtoRegE  in  1  Execute instruction is a load
- MdStartE  in  1  Execute holds a multi-cycle multiply/divide
- ForwardAE, ForwardBE  out  2 each  Execute operand select (00 register file, 01 writeback result, 10 ALUOutM, 11 never driven)
- ForwardAD, ForwardBD  out  1 each  Decode branch operand taken from ALUOutM
- StallF, StallD, StallE  out  1 each  hold the Fetch, Decode and Execute pipeline registers
- FlushE  out  1  load a bubble into the Execute register
- MdBusy  out  1  a multiply/divide is in progress

Function
REQ-003 SHALL keep internal shadow Memory-stage state {RegWriteM, MemtoRegM, WriteRegM} and Writeback-stage state {RegWriteW, WriteRegW}, all registered on clk.
REQ-004 Each clock, the W shadow SHALL load the M shadow.
REQ-005 Each clock, the M shadow SHALL load {RegWriteE, MemtoRegE, WriteRegE}, except when mdstall=1, when it SHALL load a bubble (all zero).
REQ-006 ForwardAE SHALL be 10 when RsE!=0, RegWriteM=1 and RsE==WriteRegM; else 01 when RsE!=0, RegWriteW=1 and RsE==WriteRegW; else 00. Memory takes priority over Writeback.
REQ-007 ForwardBE SHALL follow the REQ-006 rule with RtE in place of RsE.
REQ-008 ForwardAD SHALL be 1 iff RsD!=0, RegWriteM=1 and RsD==WriteRegM. ForwardBD SHALL follow the same rule with RtD.
REQ-009 lwstall SHALL be 1 when MemtoRegE=1, RegWriteE=1, WriteRegE!=0 and WriteRegE is equal to RsD or RtD.
REQ-010 branchstall SHALL be 1 when BranchD=1 and either of these holds:
- RegWriteE=1, WriteRegE!=0 and WriteRegE is equal to RsD or RtD; or
- MemtoRegM=1, WriteRegM!=0 and WriteRegM is equal to RsD or RtD.
REQ-011 A 4-bit counter mdcnt SHALL track how many cycles the current multiply/divide has spent in Execute.
REQ-012 While MdStartE=1 and mdcnt<MD_LATENCY-1: mdstall SHALL be 1 and mdcnt SHALL increment at the clock edge.
REQ-013 While MdStartE=1 and mdcnt==MD_LATENCY-1: mdstall SHALL be 0 and mdcnt SHALL return to 0 at the clock edge.
REQ-014 While MdStartE=0: mdstall SHALL be 0 and mdcnt SHALL be forced to 0.
REQ-015 With REQ-012 to REQ-014, a multiply/divide occupies Execute exactly MD_LATENCY cycles and stalls for MD_LATENCY-1 cycles. With MD_LATENCY=1 it SHALL never stall.
REQ-016 MdBusy SHALL equal (mdcnt!=0).
REQ-017 Stall and flush outputs SHALL be:
- StallF = StallD = lwstall | branchstall | mdstall
- StallE = mdstall
- FlushE = (lwstall | branchstall) & ~mdstall, so an instruction stalling in Execute is never flushed.
REQ-018 All Forward*, Stall* and FlushE outputs SHALL be combinational from the inputs and the shadow state, valid in the same cycle.
REQ-019 Register 0 SHALL never cause forwarding or stalls.

Reset
REQ-020 While rst_n=0, the M and W shadows and mdcnt SHALL be cleared immediately, without waiting for clk.
REQ-021 During and after reset, with all inputs at 0, every output SHALL be 0.
REQ-022 Reset asserted during a multiply/divide SHALL abort it: mdcnt=0 and MdBusy=0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Cycle n: RegWriteE=1, WriteRegE=8. Cycle n+1: RsE=8 -> ForwardAE=10. Cycle n+2: RsE=8 -> ForwardAE=01. Cycle n+3 -> 00.
- Same destination 8 in consecutive cycles, then RsE=RtE=8 -> ForwardAE=ForwardBE=10 (Memory priority).
- MemtoRegE=1, RegWriteE=1, WriteRegE=9, RtD=9 -> StallF=StallD=FlushE=1, StallE=0. Next cycle RsE=9 -> ForwardAE=01.
- BranchD=1, RsD=10, RegWriteE=1, WriteRegE=10 -> stall for 1 cycle. Next cycle -> ForwardAD=1, no stall.
- MD_LATENCY=4, MdStartE held 4 cycles -> StallE=1 for cycles 1-3 and 0 in cycle 4. MdBusy=1 in cycles 2-4. M shadow takes a bubble for the 3 stalled cycles.
- WriteRegE=0 with RegWriteE=1 and RsE=0 -> all forwards 00, no stall. Repeat with rst_n pulsed low mid-multiply -> MdBusy=0 immediately.
